// File: rtl/lsb_pkg.sv
// lsb_pkg: shared types and constants for the in-order load/store queue.
//   - funct3 encodings for loads and stores
//   - memory access size enum, queue FSM state enum
//   - IO_BASE and the is_io_addr helper (used when LSB_IO_GUARD_EN is defined)
//   - ROB_TAG_W: width of ROB tags
package lsb_pkg;

  localparam int unsigned ROB_TAG_W = 5;
  localparam logic [31:0] IO_BASE   = 32'h0003_0000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } mem_size_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StIssue = 1'b1
  } lsb_state_e;

  // IO space is any address with bits [17:16] both set (>= 0x30000 in the low window).
  function automatic logic is_io_addr(input logic [31:0] addr);
    return (addr & IO_BASE) == IO_BASE;
  endfunction

endpackage

// File: rtl/lsb_load_extend.sv
// lsb_load_extend: combinational load-data extension.
//   i_funct3 : load funct3 (LB/LH/LW/LBU/LHU)
//   i_raw    : raw memory data, LSB-aligned
//   o_value  : sign- or zero-extended 32-bit result
module lsb_load_extend
  import lsb_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_value
);

  always_comb begin
    o_value = i_raw;
    case (i_funct3)
      F3_LB:   o_value = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_LH:   o_value = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_LBU:  o_value = {24'b0, i_raw[7:0]};
      F3_LHU:  o_value = {16'b0, i_raw[15:0]};
      default: o_value = i_raw;
    endcase
  end

endmodule

// File: rtl/lsb_mem_queue.sv
// lsb_mem_queue: in-order load/store queue. Entries are allocated at dispatch, receive
// address/data from the RS, and issue one at a time from the head to the memory controller.
// Loads broadcast on the LS CDB; stores issue only once the ROB has committed them.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   i_clear                         : flush all uncommitted entries
//   i_alloc_*  / o_lsb_full         : dispatch allocation at the tail
//   i_lsb_*                         : RS operand delivery (CAM on ROB tag)
//   i_rob_commit_*                  : ROB store commit (CAM on ROB tag)
//   o_st_addr_*                     : pulse when a store has address+data
//   o_mem_* / i_mem_*               : memory controller handshake
//   o_cdb_ls_*                      : load result broadcast
// Configuration macro LSB_IO_GUARD_EN: when defined, loads to IO space wait for ROB commit.
module lsb_mem_queue
  import lsb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 i_clear,
  input  logic                 i_alloc_ready,
  input  logic [3:0]           i_alloc_type,
  input  logic [ROB_TAG_W-1:0] i_alloc_rob_id,
  output logic                 o_lsb_full,
  input  logic                 i_lsb_rs_ready,
  input  logic [ROB_TAG_W-1:0] i_lsb_rob_id,
  input  logic [31:0]          i_lsb_st_value,
  input  logic [31:0]          i_lsb_ptr_value,
  input  logic                 i_rob_commit_st,
  input  logic [ROB_TAG_W-1:0] i_rob_commit_id,
  output logic                 o_st_addr_ready,
  output logic [ROB_TAG_W-1:0] o_st_addr_id,
  output logic                 o_mem_req,
  output logic                 o_mem_wr,
  output logic [31:0]          o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  output logic [1:0]           o_mem_size,
  input  logic                 i_mem_done,
  input  logic [31:0]          i_mem_rdata,
  output logic                 o_cdb_ls_ready,
  output logic [ROB_TAG_W-1:0] o_cdb_ls_rob_id,
  output logic [31:0]          o_cdb_ls_value
);

  // Entry state
  logic [DEPTH-1:0]     r_valid, r_is_store, r_addr_rdy, r_committed;
  logic [2:0]           r_funct3 [DEPTH];
  logic [ROB_TAG_W-1:0] r_rob_id [DEPTH];
  logic [31:0]          r_addr   [DEPTH];
  logic [31:0]          r_data   [DEPTH];

  logic [IDX_W-1:0] r_head, r_tail;
  logic [IDX_W:0]   r_count;
  lsb_state_e       r_state, w_state_next;
  logic             r_discard;  // in-flight load was flushed; swallow its completion

  // Issued-op latch: memory outputs must not follow the head slot, which a post-flush
  // allocation may overwrite while a discarded load is still outstanding.
  logic                 r_mem_req, r_mem_wr;
  logic [31:0]          r_mem_addr, r_mem_wdata;
  mem_size_e            r_mem_size;
  logic [2:0]           r_iss_funct3;
  logic [ROB_TAG_W-1:0] r_iss_rob_id;

  logic                 r_st_rdy, r_cdb_rdy;
  logic [ROB_TAG_W-1:0] r_st_id, r_cdb_id;
  logic [31:0]          r_cdb_val;

  logic             w_full, w_load_ok, w_issue_ok, w_done, w_pop, w_drop, w_alloc;
  logic             w_commit_loads;
  logic [IDX_W:0]   w_surv;
  logic [IDX_W-1:0] w_head_nxt;
  logic [31:0]      w_ext;

  lsb_load_extend u_ext (
    .i_funct3 (r_iss_funct3),
    .i_raw    (i_mem_rdata),
    .o_value  (w_ext)
  );

`ifdef LSB_IO_GUARD_EN
  assign w_load_ok      = !is_io_addr(r_addr[r_head]) || r_committed[r_head];
  assign w_commit_loads = 1'b1;
`else
  assign w_load_ok      = 1'b1;
  assign w_commit_loads = 1'b0;
`endif

  assign w_full     = (r_count == (IDX_W+1)'(DEPTH));
  // Never start a speculative op in the same cycle it is being flushed.
  assign w_issue_ok = r_valid[r_head] && r_addr_rdy[r_head] &&
                      (r_is_store[r_head] ? r_committed[r_head] : w_load_ok) &&
                      !(i_clear && !r_committed[r_head]);
  assign w_done     = rdy_in && (r_state == StIssue) && i_mem_done;
  assign w_pop      = w_done && !r_discard;
  assign w_drop     = r_discard || (i_clear && !r_committed[r_head]);
  // A pop frees the head slot this cycle, so a full queue can still accept one alloc.
  assign w_alloc    = i_alloc_ready && !i_clear && (!w_full || w_pop);
  assign w_head_nxt = r_head + IDX_W'(w_pop);

  // Survivors of a flush: committed entries, minus the one popping this cycle.
  always_comb begin
    w_surv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_committed[i] && !(w_pop && (IDX_W'(i) == r_head))) begin
        w_surv = w_surv + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_issue_ok) w_state_next = StIssue;
      StIssue: if (i_mem_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= StIdle;
    else if (rdy_in) r_state <= w_state_next;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid      <= '0;
      r_is_store   <= '0;
      r_addr_rdy   <= '0;
      r_committed  <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_discard    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_size   <= SzByte;
      r_iss_funct3 <= '0;
      r_iss_rob_id <= '0;
      r_st_rdy     <= 1'b0;
      r_st_id      <= '0;
      r_cdb_rdy    <= 1'b0;
      r_cdb_id     <= '0;
      r_cdb_val    <= '0;
    end else if (rdy_in) begin
      r_st_rdy  <= 1'b0;
      r_cdb_rdy <= 1'b0;

      if (r_state == StIdle && w_issue_ok) begin
        r_mem_req    <= 1'b1;
        r_mem_wr     <= r_is_store[r_head];
        r_mem_addr   <= r_addr[r_head];
        r_mem_wdata  <= r_data[r_head];
        r_mem_size   <= mem_size_e'(r_funct3[r_head][1:0]);
        r_iss_funct3 <= r_funct3[r_head];
        r_iss_rob_id <= r_rob_id[r_head];
      end

      if (w_done) begin
        r_mem_req <= 1'b0;
        r_discard <= 1'b0;
        if (!r_mem_wr && !w_drop) begin
          r_cdb_rdy <= 1'b1;
          r_cdb_id  <= r_iss_rob_id;
          r_cdb_val <= w_ext;
        end
      end else if (i_clear && r_state == StIssue && !r_committed[r_head]) begin
        r_discard <= 1'b1;
      end

      if (i_clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!r_committed[i]) r_valid[i] <= 1'b0;
        end
      end
      if (w_pop) r_valid[r_head] <= 1'b0;

      if (!i_clear) begin
        if (i_lsb_rs_ready) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_rob_id[i] == i_lsb_rob_id) begin
              r_addr_rdy[i] <= 1'b1;
              if (r_is_store[i]) begin
                r_st_rdy <= 1'b1;
                r_st_id  <= i_lsb_rob_id;
              end
            end
          end
        end
        if (i_rob_commit_st) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_rob_id[i] == i_rob_commit_id && (r_is_store[i] || w_commit_loads))
              r_committed[i] <= 1'b1;
          end
        end
        // Last so that an alloc into the slot being popped wins.
        if (w_alloc) begin
          r_valid[r_tail]     <= 1'b1;
          r_is_store[r_tail]  <= i_alloc_type[3];
          r_addr_rdy[r_tail]  <= 1'b0;
          r_committed[r_tail] <= 1'b0;
        end
      end

      r_head <= w_head_nxt;
      if (i_clear) begin
        r_tail  <= w_head_nxt + w_surv[IDX_W-1:0];
        r_count <= w_surv;
      end else begin
        r_tail  <= r_tail + IDX_W'(w_alloc);
        r_count <= r_count + (IDX_W+1)'(w_alloc) - (IDX_W+1)'(w_pop);
      end
    end
  end

  // Payload storage needs no reset; validity is tracked in the flag registers.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !i_clear) begin
      if (i_lsb_rs_ready) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && r_rob_id[i] == i_lsb_rob_id) begin
            r_addr[i] <= i_lsb_ptr_value;
            r_data[i] <= i_lsb_st_value;
          end
        end
      end
      if (w_alloc) begin
        r_funct3[r_tail] <= i_alloc_type[2:0];
        r_rob_id[r_tail] <= i_alloc_rob_id;
      end
    end
  end

  assign o_lsb_full      = w_full;
  assign o_st_addr_ready = r_st_rdy && rdy_in;
  assign o_st_addr_id    = r_st_id;
  assign o_mem_req       = r_mem_req;
  assign o_mem_wr        = r_mem_wr;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_mem_size      = r_mem_size;
  assign o_cdb_ls_ready  = r_cdb_rdy && rdy_in;
  assign o_cdb_ls_rob_id = r_cdb_id;
  assign o_cdb_ls_value  = r_cdb_val;

endmodule

// File: tb/tb_lsb_mem_queue.sv
// Self-checking bench for lsb_mem_queue: table of single-load vectors plus hand-written
// sequences for stores, full queue, flush, rdy gating, IO guard and async reset.
module tb_lsb_mem_queue;
  import lsb_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, i_clear;
  logic        i_alloc_ready;
  logic [3:0]  i_alloc_type;
  logic [4:0]  i_alloc_rob_id;
  logic        o_lsb_full;
  logic        i_lsb_rs_ready;
  logic [4:0]  i_lsb_rob_id;
  logic [31:0] i_lsb_st_value, i_lsb_ptr_value;
  logic        i_rob_commit_st;
  logic [4:0]  i_rob_commit_id;
  logic        o_st_addr_ready;
  logic [4:0]  o_st_addr_id;
  logic        o_mem_req, o_mem_wr;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [1:0]  o_mem_size;
  logic        i_mem_done;
  logic [31:0] i_mem_rdata;
  logic        o_cdb_ls_ready;
  logic [4:0]  o_cdb_ls_rob_id;
  logic [31:0] o_cdb_ls_value;

  always #5 clk_in = ~clk_in;

  lsb_mem_queue #(.DEPTH(8), .IDX_W(3)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .i_clear         (i_clear),
    .i_alloc_ready   (i_alloc_ready),
    .i_alloc_type    (i_alloc_type),
    .i_alloc_rob_id  (i_alloc_rob_id),
    .o_lsb_full      (o_lsb_full),
    .i_lsb_rs_ready  (i_lsb_rs_ready),
    .i_lsb_rob_id    (i_lsb_rob_id),
    .i_lsb_st_value  (i_lsb_st_value),
    .i_lsb_ptr_value (i_lsb_ptr_value),
    .i_rob_commit_st (i_rob_commit_st),
    .i_rob_commit_id (i_rob_commit_id),
    .o_st_addr_ready (o_st_addr_ready),
    .o_st_addr_id    (o_st_addr_id),
    .o_mem_req       (o_mem_req),
    .o_mem_wr        (o_mem_wr),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_size      (o_mem_size),
    .i_mem_done      (i_mem_done),
    .i_mem_rdata     (i_mem_rdata),
    .o_cdb_ls_ready  (o_cdb_ls_ready),
    .o_cdb_ls_rob_id (o_cdb_ls_rob_id),
    .o_cdb_ls_value  (o_cdb_ls_value)
  );

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  tag;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard side: every CDB pulse must match the oldest expected load result.
  always @(negedge clk_in) begin
    if (!rst_in && o_cdb_ls_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cdb_unexpected: got tag %0d value 0x%08h, expected no broadcast",
                 o_cdb_ls_rob_id, o_cdb_ls_value);
      end else begin
        mon_e = sb_q.pop_front();
        check("cdb_tag", 32'(o_cdb_ls_rob_id), 32'(mon_e.tag));
        check("cdb_value", o_cdb_ls_value, mon_e.value);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic alloc(input logic is_st, input logic [2:0] f3, input logic [4:0] tag);
    i_alloc_ready  = 1'b1;
    i_alloc_type   = {is_st, f3};
    i_alloc_rob_id = tag;
    tick();
    i_alloc_ready  = 1'b0;
  endtask

  task automatic deliver(input logic [4:0] tag, input logic [31:0] addr, input logic [31:0] data);
    i_lsb_rs_ready  = 1'b1;
    i_lsb_rob_id    = tag;
    i_lsb_ptr_value = addr;
    i_lsb_st_value  = data;
    tick();
    i_lsb_rs_ready  = 1'b0;
  endtask

  task automatic commit(input logic [4:0] tag);
    i_rob_commit_st = 1'b1;
    i_rob_commit_id = tag;
    tick();
    i_rob_commit_st = 1'b0;
  endtask

  task automatic clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (o_mem_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check(name, 32'(o_mem_req), 32'd1);
  endtask

  task automatic finish_mem(input logic [31:0] rdata, input logic push,
                            input logic [4:0] tag, input logic [31:0] exp);
    exp_t e;
    i_mem_done  = 1'b1;
    i_mem_rdata = rdata;
    if (push) begin
      e.tag   = tag;
      e.value = exp;
      sb_q.push_back(e);
    end
    tick();
    i_mem_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{F3_LW,  5'd3, 32'h0000_0100, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{F3_LB,  5'd4, 32'h0000_0010, 32'h0000_0080, 32'hFFFF_FF80};
    vecs[2] = '{F3_LBU, 5'd6, 32'h0000_0010, 32'h0000_0080, 32'h0000_0080};
    vecs[3] = '{F3_LH,  5'd7, 32'h0000_0022, 32'h0000_8001, 32'hFFFF_8001};
    vecs[4] = '{F3_LHU, 5'd8, 32'h0000_0024, 32'hABCD_8001, 32'h0000_8001};
    vecs[5] = '{F3_LB,  5'd9, 32'h0000_0031, 32'h1234_567F, 32'h0000_007F};

    rst_in = 1'b1; rdy_in = 1'b1; i_clear = 1'b0;
    i_alloc_ready = 1'b0; i_alloc_type = '0; i_alloc_rob_id = '0;
    i_lsb_rs_ready = 1'b0; i_lsb_rob_id = '0; i_lsb_st_value = '0; i_lsb_ptr_value = '0;
    i_rob_commit_st = 1'b0; i_rob_commit_id = '0; i_mem_done = 1'b0; i_mem_rdata = '0;
    tick();
    tick();
    check("rst_mem_req",  32'(o_mem_req),       32'd0);
    check("rst_full",     32'(o_lsb_full),      32'd0);
    check("rst_cdb",      32'(o_cdb_ls_ready),  32'd0);
    check("rst_st_rdy",   32'(o_st_addr_ready), 32'd0);
    check("rst_mem_addr", o_mem_addr,           32'd0);
    rst_in = 1'b0;
    tick();

    // Single loads from the vector table
    for (int i = 0; i < 6; i++) begin
      alloc(1'b0, vecs[i].f3, vecs[i].tag);
      deliver(vecs[i].tag, vecs[i].addr, 32'h0);
      check("vec_no_st_rdy", 32'(o_st_addr_ready), 32'd0);
      wait_req("vec_req");
      check("vec_addr", o_mem_addr, vecs[i].addr);
      check("vec_size", 32'(o_mem_size), 32'(vecs[i].f3[1:0]));
      check("vec_wr", 32'(o_mem_wr), 32'd0);
      finish_mem(vecs[i].rdata, 1'b1, vecs[i].tag, vecs[i].exp);
      check("vec_cdb_pulse", 32'(o_cdb_ls_ready), 32'd1);
      check("vec_req_drop", 32'(o_mem_req), 32'd0);
      tick();
      check("vec_cdb_once", 32'(o_cdb_ls_ready), 32'd0);
    end

    // Store waits for commit
    alloc(1'b1, F3_SW, 5'd5);
    deliver(5'd5, 32'h0000_0200, 32'hDEAD_BEEF);
    check("st_addr_ready", 32'(o_st_addr_ready), 32'd1);
    check("st_addr_id", 32'(o_st_addr_id), 32'd5);
    tick();
    check("st_addr_pulse", 32'(o_st_addr_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_wait_commit", 32'(o_mem_req), 32'd0);
    end
    commit(5'd5);
    wait_req("st_req");
    check("st_wr", 32'(o_mem_wr), 32'd1);
    check("st_size", 32'(o_mem_size), 32'd2);
    check("st_addr", o_mem_addr, 32'h0000_0200);
    check("st_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    finish_mem(32'h0, 1'b0, 5'd0, 32'h0);
    check("st_req_drop", 32'(o_mem_req), 32'd0);
    check("st_no_cdb", 32'(o_cdb_ls_ready), 32'd0);

    // Fill to DEPTH, extra alloc ignored, pop+alloc keeps it full
    for (int k = 0; k < 7; k++) alloc(1'b0, F3_LW, 5'(10 + k));
    check("fill_7_not_full", 32'(o_lsb_full), 32'd0);
    alloc(1'b0, F3_LW, 5'd17);
    check("fill_8_full", 32'(o_lsb_full), 32'd1);
    alloc(1'b0, F3_LW, 5'd20);
    check("full_extra_alloc", 32'(o_lsb_full), 32'd1);
    deliver(5'd10, 32'h0000_0040, 32'h0);
    wait_req("full_req");
    check("full_addr", o_mem_addr, 32'h0000_0040);
    i_alloc_ready = 1'b1; i_alloc_type = {1'b0, F3_LW}; i_alloc_rob_id = 5'd21;
    finish_mem(32'h0000_0055, 1'b1, 5'd10, 32'h0000_0055);
    i_alloc_ready = 1'b0;
    check("pop_alloc_full", 32'(o_lsb_full), 32'd1);
    clear();
    check("clear_empty", 32'(o_lsb_full), 32'd0);

    // Flush with committed store in flight and three younger loads
    alloc(1'b1, F3_SW, 5'd1);
    alloc(1'b0, F3_LW, 5'd2);
    alloc(1'b0, F3_LW, 5'd3);
    alloc(1'b0, F3_LW, 5'd4);
    deliver(5'd1, 32'h0000_0300, 32'hCAFE_F00D);
    deliver(5'd2, 32'h0000_0304, 32'h0);
    deliver(5'd3, 32'h0000_0308, 32'h0);
    deliver(5'd4, 32'h0000_030C, 32'h0);
    commit(5'd1);
    wait_req("clr_st_req");
    check("clr_st_wr", 32'(o_mem_wr), 32'd1);
    clear();
    check("clr_st_hold", 32'(o_mem_req), 32'd1);
    check("clr_st_addr", o_mem_addr, 32'h0000_0300);
    finish_mem(32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("clr_loads_gone", 32'(o_mem_req), 32'd0);
    end
    for (int k = 0; k < 7; k++) alloc(1'b0, F3_LW, 5'(k));
    check("clr_count0_7", 32'(o_lsb_full), 32'd0);
    alloc(1'b0, F3_LW, 5'd7);
    check("clr_count0_8", 32'(o_lsb_full), 32'd1);
    clear();

    // Flush with a load in flight: request held, result discarded, slot reused
    alloc(1'b0, F3_LW, 5'd9);
    deliver(5'd9, 32'h0000_0500, 32'h0);
    wait_req("ld_flush_req");
    clear();
    check("ld_flush_hold", 32'(o_mem_req), 32'd1);
    alloc(1'b0, F3_LW, 5'd12);
    deliver(5'd12, 32'h0000_0600, 32'h0);
    check("ld_flush_addr_hold", o_mem_addr, 32'h0000_0500);
    finish_mem(32'h0000_0077, 1'b0, 5'd0, 32'h0);
    check("ld_flush_no_cdb", 32'(o_cdb_ls_ready), 32'd0);
    wait_req("ld_after_flush_req");
    check("ld_after_flush_addr", o_mem_addr, 32'h0000_0600);
    finish_mem(32'h0000_0099, 1'b1, 5'd12, 32'h0000_0099);
    tick();

    // rdy_in low freezes the handshake
    alloc(1'b0, F3_LHU, 5'd13);
    deliver(5'd13, 32'h0000_0700, 32'h0);
    wait_req("rdy_req");
    rdy_in = 1'b0;
    i_mem_done = 1'b1;
    i_mem_rdata = 32'h0000_F00F;
    tick();
    tick();
    check("rdy_hold_req", 32'(o_mem_req), 32'd1);
    rdy_in = 1'b1;
    finish_mem(32'h0000_F00F, 1'b1, 5'd13, 32'h0000_F00F);
    check("rdy_cdb_pulse", 32'(o_cdb_ls_ready), 32'd1);
    tick();

    // IO-space load
    alloc(1'b0, F3_LW, 5'd14);
    deliver(5'd14, 32'h0003_0004, 32'h0);
`ifdef LSB_IO_GUARD_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("io_wait_commit", 32'(o_mem_req), 32'd0);
    end
    commit(5'd14);
    wait_req("io_req");
`else
    tick();
    check("io_issue_now", 32'(o_mem_req), 32'd1);
`endif
    check("io_addr", o_mem_addr, 32'h0003_0004);
    finish_mem(32'h0000_1111, 1'b1, 5'd14, 32'h0000_1111);
    tick();

    // Async reset mid-transaction
    alloc(1'b0, F3_LW, 5'd15);
    deliver(5'd15, 32'h0000_0800, 32'h0);
    wait_req("arst_req");
    #2 rst_in = 1'b1;
    #1;
    check("arst_req_drop", 32'(o_mem_req), 32'd0);
    check("arst_addr_zero", o_mem_addr, 32'd0);
    tick();
    rst_in = 1'b0;
    tick();
    tick();
    check("arst_idle", 32'(o_mem_req), 32'd0);
    check("arst_no_cdb", 32'(o_cdb_ls_ready), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
